// File: rtl/mult_div.sv
// mult_div: multi-cycle HI/LO multiply/divide unit with mthi/mtlo and async active-low reset
module mult_div #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic [2:0]  MDOp,
  input  logic        start,
  input  logic        Interrupt,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] prod_s, prod_u;
  logic [31:0] b_nz, abs_a, abs_b, qs_mag, rs_mag, qs, rs, qu, ru;
  logic        launch;
  // Results from the latched operands; the signed divide works on magnitudes so
  // 0x80000000 / -1 wraps to 0x80000000 and a zero divisor never reaches the divider.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    b_nz   = (b_q == 32'd0) ? 32'd1 : b_q;
    abs_a  = a_q[31] ? -a_q : a_q;
    abs_b  = b_q[31] ? -b_q : b_nz;
    qs_mag = abs_a / abs_b;
    rs_mag = abs_a % abs_b;
    qs     = (a_q[31] ^ b_q[31]) ? -qs_mag : qs_mag;
    rs     = a_q[31] ? -rs_mag : rs_mag;
    qu     = a_q / b_nz;
    ru     = a_q % b_nz;
  end
  // Next-state: launch or mthi/mtlo from IDLE, count down and commit from RUN.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    launch  = start && (MDOp >= 3'd1) && (MDOp <= 3'd4) && !Interrupt;
    if (state_q == IDLE) begin
      if (launch) begin
        state_d = RUN;
        a_d     = D1;
        b_d     = D2;
        op_d    = MDOp;
        cnt_d   = (MDOp <= 3'd2) ? 32'(MULT_CYCLES) : 32'(DIV_CYCLES);
      end else if (!Interrupt) begin
        hi_d = (MDOp == 3'd5) ? D1 : hi_q;
        lo_d = (MDOp == 3'd6) ? D1 : lo_q;
      end
    end else if (cnt_q == 32'd1) begin
      state_d = IDLE;
      cnt_d   = 32'd0;
      if (op_q == 3'd1) {hi_d, lo_d} = prod_s;
      else if (op_q == 3'd2) {hi_d, lo_d} = prod_u;
      else if (b_q != 32'd0) begin
        hi_d = (op_q == 3'd3) ? rs : ru;
        lo_d = (op_q == 3'd3) ? qs : qu;
      end
    end else begin
      cnt_d = cnt_q - 32'd1;
    end
  end
  // State and result registers; reset clears everything and aborts any operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign Busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;
endmodule
